// File: rtl/cndm_micro_pkg.sv
// Shared constants for the micro control-init engine: global register
// offsets, AXI-lite response codes and the sequencer state encoding.
package cndm_micro_pkg;

  // Global register block offsets (relative to the global base)
  localparam logic [15:0] CNDM_REG_PORT_COUNT  = 16'h0100;
  localparam logic [15:0] CNDM_REG_PORT_OFFSET = 16'h0104;
  localparam logic [15:0] CNDM_REG_PORT_STRIDE = 16'h0108;

  // AXI-lite response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Sequencer states
  typedef logic [2:0] cndm_state_t;
  localparam cndm_state_t ST_IDLE    = 3'd0;
  localparam cndm_state_t ST_RD_REQ  = 3'd1;
  localparam cndm_state_t ST_RD_RESP = 3'd2;
  localparam cndm_state_t ST_CHECK   = 3'd3;
  localparam cndm_state_t ST_WR_REQ  = 3'd4;
  localparam cndm_state_t ST_WR_RESP = 3'd5;
  localparam cndm_state_t ST_FIN     = 3'd6;

endpackage

// File: rtl/taxi_axil_if.sv
// Minimal AXI-lite interface with split read/write master and slave views.
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; a source holds valid and its
// payload stable until that edge, and ready may rise before, with, or after
// valid.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport rd_mst (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

  modport rd_slv (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cndm_micro_ctrl_init.sv
// Self-init engine: on start, reads port count/offset/stride from the global
// register block, then writes wr_data to REG_OFF inside every port window.
// At most one AXI-lite transaction is ever outstanding.
module cndm_micro_ctrl_init
  import cndm_micro_pkg::*;
#(
  parameter int          MAX_PORTS = 8,
  parameter logic [15:0] REG_OFF   = 16'h0100,
  parameter logic [15:0] GLB_BASE  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.wr_mst m_axil_wr,
  taxi_axil_if.rd_mst m_axil_rd,
  input  logic        start,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] port_count,
  output logic [31:0] port_offset,
  output logic [31:0] port_stride,
  output cndm_state_t dbg_state
);

  localparam int AW = m_axil_wr.ADDR_W;

  cndm_state_t   r_state;
  logic [1:0]    r_idx;
  logic          r_aw_done;
  logic          r_w_done;
  logic [31:0]   r_wr_data;
  logic [31:0]   r_port;
  logic [31:0]   r_count;
  logic [31:0]   r_offset;
  logic [31:0]   r_stride;
  logic [AW-1:0] r_addr_acc;
  logic          r_error;

  logic w_arvalid;
  logic w_awvalid;
  logic w_wvalid;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_b_hs;

  // Valids are decoded from state so a reset drops them on the next cycle.
  // AW and W are tracked separately: each stays up until its own handshake.
  assign w_arvalid = (r_state == ST_RD_REQ);
  assign w_awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
  assign w_wvalid  = (r_state == ST_WR_REQ) && !r_w_done;
  assign w_ar_hs   = w_arvalid && m_axil_rd.arready;
  assign w_r_hs    = (r_state == ST_RD_RESP) && m_axil_rd.rvalid;
  assign w_aw_ok   = r_aw_done || (w_awvalid && m_axil_wr.awready);
  assign w_w_ok    = r_w_done || (w_wvalid && m_axil_wr.wready);
  assign w_b_hs    = (r_state == ST_WR_RESP) && m_axil_wr.bvalid;

  // Read channel: global register index 0..2 maps to consecutive words
  assign m_axil_rd.araddr  = AW'(GLB_BASE) + AW'(CNDM_REG_PORT_COUNT) + AW'({r_idx, 2'b00});
  assign m_axil_rd.arprot  = 3'b000;
  assign m_axil_rd.arvalid = w_arvalid;
  assign m_axil_rd.rready  = (r_state == ST_RD_RESP);

  // Write channel: address comes from the running accumulator
  assign m_axil_wr.awaddr  = r_addr_acc;
  assign m_axil_wr.awprot  = 3'b000;
  assign m_axil_wr.awvalid = w_awvalid;
  assign m_axil_wr.wdata   = r_wr_data;
  assign m_axil_wr.wstrb   = '1;
  assign m_axil_wr.wvalid  = w_wvalid;
  assign m_axil_wr.bready  = (r_state == ST_WR_RESP);

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign error       = r_error;
  assign port_count  = r_count;
  assign port_offset = r_offset;
  assign port_stride = r_stride;
  assign dbg_state   = r_state;

  // Sequencer: three global reads, range check, then one write per port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_wr_data  <= 32'd0;
      r_port     <= 32'd0;
      r_count    <= 32'd0;
      r_offset   <= 32'd0;
      r_stride   <= 32'd0;
      r_addr_acc <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_wr_data <= wr_data;
            r_error   <= 1'b0;
            r_idx     <= 2'd0;
            r_state   <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (w_ar_hs) r_state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (w_r_hs) begin
            // Data is kept even on an error response
            case (r_idx)
              2'd0:    r_count  <= m_axil_rd.rdata;
              2'd1:    r_offset <= m_axil_rd.rdata;
              default: r_stride <= m_axil_rd.rdata;
            endcase
            if (m_axil_rd.rresp != AXI_RESP_OKAY) begin
              r_error <= 1'b1;
              r_state <= ST_FIN;
            end else if (r_idx == 2'd2) begin
              r_state <= ST_CHECK;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_CHECK: begin
          if (r_count == 32'd0) begin
            r_state <= ST_FIN;
          end else if (r_count > 32'(MAX_PORTS)) begin
            r_error <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_addr_acc <= AW'(r_offset) + AW'(REG_OFF);
            r_port     <= 32'd0;
            r_state    <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_ok && w_w_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_WR_RESP;
          end else begin
            r_aw_done <= w_aw_ok;
            r_w_done  <= w_w_ok;
          end
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            if (m_axil_wr.bresp != AXI_RESP_OKAY) begin
              r_error <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              // Stride accumulation replaces a port*stride multiply
              r_addr_acc <= r_addr_acc + AW'(r_stride);
              if (r_port == r_count - 32'd1) begin
                r_state <= ST_FIN;
              end else begin
                r_port  <= r_port + 32'd1;
                r_state <= ST_WR_REQ;
              end
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cndm_micro_ctrl_init.sv
// Bench for cndm_micro_ctrl_init: an AXI-lite slave with configurable waits,
// a transaction-level reference model, and one monitor comparing every
// handshake and protocol rule against it.
module tb_cndm_micro_ctrl_init;
  import cndm_micro_pkg::*;

  localparam int W = 65;  // {is_write, addr[31:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] port_count;
  logic [31:0] port_offset;
  logic [31:0] port_stride;
  cndm_state_t dbg_state;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

  cndm_micro_ctrl_init #(.MAX_PORTS(8), .REG_OFF(16'h0100), .GLB_BASE(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_axil_wr   (axil),
    .m_axil_rd   (axil),
    .start       (start),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .port_count  (port_count),
    .port_offset (port_offset),
    .port_stride (port_stride),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  wlog[$];
  logic [31:0]  m_regs[3];
  bit           e_err;

  int aw_hi, w_hi, b_cnt, ar_cnt_m, done_cnt;

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected transaction list from the global register values alone.
  task automatic model(input logic [31:0] cnt, input logic [31:0] off, input logic [31:0] str,
                       input logic [31:0] wd, input int rderr, input int wrerr);
    logic [31:0] a;
    logic [31:0] vals[3];
    exp_q.delete();
    e_err = 1'b0;
    vals[0] = cnt;
    vals[1] = off;
    vals[2] = str;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      exp_q.push_back({1'b0, a, 32'h0});
      m_regs[i] = vals[i];
      if (i == rderr) begin
        e_err = 1'b1;
        return;
      end
    end
    if (cnt == 0) return;
    if (cnt > 8) begin
      e_err = 1'b1;
      return;
    end
    for (int p = 0; p < int'(cnt); p++) begin
      a = off + 32'h100 + 32'(p) * str;
      exp_q.push_back({1'b1, a, wd});
      if (p == wrerr) begin
        e_err = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- slave ----------------
  logic [31:0] cfg_count, cfg_offset, cfg_stride;
  int cfg_ar_wait, cfg_aw_wait, cfg_w_wait, cfg_r_dly, cfg_b_dly, cfg_rd_err, cfg_wr_err;
  int s_ar_cnt, s_aw_cnt, s_w_cnt, s_r_dly, s_b_dly, s_wr_num;
  logic s_r_pend, s_b_aw, s_b_w, s_rst;
  logic s_hs_ar, s_hs_aw, s_hs_w, s_hs_r, s_hs_b;
  logic [31:0] s_r_addr;

  function automatic logic [31:0] reg_val(input logic [31:0] a);
    case (a)
      32'h100: return cfg_count;
      32'h104: return cfg_offset;
      32'h108: return cfg_stride;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic slave_clear();
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = 32'd0; axil.rresp = 2'b00;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
    s_ar_cnt = 0; s_aw_cnt = 0; s_w_cnt = 0; s_r_dly = 0; s_b_dly = 0;
    s_r_pend = 1'b0; s_b_aw = 1'b0; s_b_w = 1'b0;
  endtask

  initial begin
    cfg_count = 0; cfg_offset = 0; cfg_stride = 0;
    cfg_ar_wait = 0; cfg_aw_wait = 0; cfg_w_wait = 0; cfg_r_dly = 0; cfg_b_dly = 0;
    cfg_rd_err = 3; cfg_wr_err = -1; s_wr_num = 0; s_r_addr = 0;
    slave_clear();
    forever begin
      @(negedge clk);
      s_rst   = rst;
      s_hs_ar = axil.arvalid && axil.arready;
      s_hs_aw = axil.awvalid && axil.awready;
      s_hs_w  = axil.wvalid && axil.wready;
      s_hs_r  = axil.rvalid && axil.rready;
      s_hs_b  = axil.bvalid && axil.bready;
      if (s_hs_ar) s_r_addr = axil.araddr;
      @(posedge clk);
      #1;
      if (s_rst) begin
        slave_clear();
      end else begin
        if (s_hs_ar) begin s_r_pend = 1'b1; s_r_dly = 0; end
        if (s_hs_r) axil.rvalid = 1'b0;
        if (s_r_pend && !axil.rvalid) begin
          if (s_r_dly >= cfg_r_dly) begin
            axil.rvalid = 1'b1;
            axil.rdata  = reg_val(s_r_addr);
            axil.rresp  = (cfg_rd_err < 3 && s_r_addr == 32'h100 + 32'(4 * cfg_rd_err)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            s_r_pend = 1'b0;
          end else s_r_dly++;
        end
        if (s_hs_aw) s_b_aw = 1'b1;
        if (s_hs_w) s_b_w = 1'b1;
        if (s_hs_b) axil.bvalid = 1'b0;
        if (s_b_aw && s_b_w && !axil.bvalid) begin
          if (s_b_dly >= cfg_b_dly) begin
            axil.bvalid = 1'b1;
            axil.bresp  = (s_wr_num == cfg_wr_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            s_wr_num++;
            s_b_aw = 1'b0; s_b_w = 1'b0; s_b_dly = 0;
          end else s_b_dly++;
        end
        if (!axil.arvalid) begin axil.arready = 1'b0; s_ar_cnt = 0; end
        else if (s_ar_cnt >= cfg_ar_wait) axil.arready = 1'b1;
        else s_ar_cnt++;
        if (!axil.awvalid) begin axil.awready = 1'b0; s_aw_cnt = 0; end
        else if (s_aw_cnt >= cfg_aw_wait) axil.awready = 1'b1;
        else s_aw_cnt++;
        if (!axil.wvalid) begin axil.wready = 1'b0; s_w_cnt = 0; end
        else if (s_w_cnt >= cfg_w_wait) axil.wready = 1'b1;
        else s_w_cnt++;
      end
    end
  end

  // ---------------- monitor / compare ----------------
  int          outstanding;
  logic        m_pend_aw, m_pend_w, m_prev_aw_stall, m_prev_ar_stall;
  logic [31:0] m_aw_addr, m_w_data, m_prev_awaddr, m_prev_araddr;
  logic [W-1:0] m_act, m_exp;

  initial begin
    outstanding = 0; m_pend_aw = 0; m_pend_w = 0; m_prev_aw_stall = 0; m_prev_ar_stall = 0;
    m_aw_addr = 0; m_w_data = 0; m_prev_awaddr = 0; m_prev_araddr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0; m_pend_aw = 0; m_pend_w = 0;
        m_prev_aw_stall = 0; m_prev_ar_stall = 0;
      end else begin
        if (axil.arvalid || axil.awvalid || axil.wvalid) begin
          chk(!(axil.arvalid && (axil.awvalid || axil.wvalid)), "rd_wr_overlap",
              {axil.arvalid, axil.awvalid, axil.wvalid}, 0);
          chk(outstanding == 0, "outstanding", outstanding, 0);
        end
        if (m_prev_aw_stall)
          chk(axil.awvalid && axil.awaddr == m_prev_awaddr, "aw_hold", {axil.awvalid, axil.awaddr}, {1'b1, m_prev_awaddr});
        if (m_prev_ar_stall)
          chk(axil.arvalid && axil.araddr == m_prev_araddr, "ar_hold", {axil.arvalid, axil.araddr}, {1'b1, m_prev_araddr});
        if (done) begin
          done_cnt++;
          chk(busy == 1'b1, "busy_with_done", busy, 1);
        end
        if (axil.awvalid) aw_hi++;
        if (axil.wvalid) w_hi++;
        if (axil.arvalid && axil.arready) begin
          ar_cnt_m++;
          outstanding++;
          m_act = {1'b0, axil.araddr, 32'h0};
          chk(axil.arprot == 3'b000, "arprot", axil.arprot, 0);
          if (exp_q.size() == 0) chk(1'b0, "unexpected_read", m_act, 0);
          else begin
            m_exp = exp_q.pop_front();
            chk(m_act == m_exp, "txn_read", m_act, m_exp);
          end
        end
        if (axil.rvalid && axil.rready) outstanding--;
        if (axil.awvalid && axil.awready) begin
          m_pend_aw = 1'b1;
          m_aw_addr = axil.awaddr;
        end
        if (axil.wvalid && axil.wready) begin
          m_pend_w = 1'b1;
          m_w_data = axil.wdata;
          chk(axil.wstrb == 4'hF, "wstrb", axil.wstrb, 4'hF);
        end
        if (m_pend_aw && m_pend_w) begin
          m_pend_aw = 1'b0;
          m_pend_w  = 1'b0;
          outstanding++;
          wlog.push_back(m_aw_addr);
          m_act = {1'b1, m_aw_addr, m_w_data};
          if (exp_q.size() == 0) chk(1'b0, "unexpected_write", m_act, 0);
          else begin
            m_exp = exp_q.pop_front();
            chk(m_act == m_exp, "txn_write", m_act, m_exp);
          end
        end
        if (axil.bvalid && axil.bready) begin
          b_cnt++;
          outstanding--;
        end
        m_prev_aw_stall = axil.awvalid && !axil.awready;
        m_prev_awaddr   = axil.awaddr;
        m_prev_ar_stall = axil.arvalid && !axil.arready;
        m_prev_araddr   = axil.araddr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) m_regs[i] = 32'd0;
  endtask

  task automatic run_seq(input logic [31:0] cnt, input logic [31:0] off, input logic [31:0] str,
                         input logic [31:0] wd, input int arw, input int aww, input int ww,
                         input int rdl, input int bdl, input int rderr, input int wrerr, input bit poke);
    int c;
    cfg_count = cnt; cfg_offset = off; cfg_stride = str;
    cfg_ar_wait = arw; cfg_aw_wait = aww; cfg_w_wait = ww; cfg_r_dly = rdl; cfg_b_dly = bdl;
    cfg_rd_err = rderr; cfg_wr_err = wrerr; s_wr_num = 0;
    aw_hi = 0; w_hi = 0; b_cnt = 0; ar_cnt_m = 0; done_cnt = 0;
    wlog.delete();
    model(cnt, off, str, wd, rderr, wrerr);
    @(posedge clk); #1; start = 1'b1; wr_data = wd;
    @(posedge clk); #1; start = poke; wr_data = $urandom();
    @(negedge clk);
    chk(busy == 1'b1, "busy_after_start", busy, 1);
    chk(error == 1'b0, "error_cleared_on_start", error, 0);
    @(posedge clk); #1; start = 1'b0;
    c = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk(done == 1'b1, "done_timeout", done, 1);
    if (!done) begin
      do_reset();
      return;
    end
    chk(error == e_err, "error_flag", error, e_err);
    chk(port_count == m_regs[0], "port_count", port_count, m_regs[0]);
    chk(port_offset == m_regs[1], "port_offset", port_offset, m_regs[1]);
    chk(port_stride == m_regs[2], "port_stride", port_stride, m_regs[2]);
    // A start arriving in the FIN cycle must be ignored
    if (poke) start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk(busy == 1'b0, "busy_after_fin", busy, 0);
    chk(done == 1'b0, "done_one_cycle", done, 0);
    chk(done_cnt == 1, "done_pulse_count", done_cnt, 1);
    chk(exp_q.size() == 0, "txn_remaining", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "start_in_fin_ignored", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    logic [31:0] r_cnt;
    for (int i = 0; i < 3; i++) m_regs[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk({busy, done, error} == 3'b000, "reset_flags", {busy, done, error}, 0);
    chk(port_count == 0 && port_offset == 0 && port_stride == 0, "reset_regs",
        {port_count, port_offset}, 0);
    chk({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} == 5'b0,
        "reset_axil", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Two ports, zero-wait slave; start also re-pulsed while busy and in FIN
    run_seq(32'd2, 32'h0001_0000, 32'h0001_0000, 32'h1, 0, 0, 0, 0, 0, 3, -1, 1'b1);
    chk(wlog.size() == 2, "t1_write_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk(wlog[0] == 32'h0001_0100, "t1_addr0", wlog[0], 32'h0001_0100);
      chk(wlog[1] == 32'h0002_0100, "t1_addr1", wlog[1], 32'h0002_0100);
    end
    chk(b_cnt == 2, "t1_b_count", b_cnt, 2);
    chk(port_count == 32'd2, "t1_port_count", port_count, 2);

    // awready delayed 3 cycles, wready immediate
    run_seq(32'd2, 32'h0001_0000, 32'h0001_0000, 32'h1, 0, 3, 0, 0, 0, 3, -1, 1'b0);
    chk(aw_hi == 8, "t2_awvalid_cycles", aw_hi, 8);
    chk(w_hi == 2, "t2_wvalid_cycles", w_hi, 2);
    chk(b_cnt == 2, "t2_b_count", b_cnt, 2);
    if (wlog.size() == 2) chk(wlog[1] == 32'h0002_0100, "t2_addr1", wlog[1], 32'h0002_0100);
    else chk(1'b0, "t2_write_count", wlog.size(), 2);

    // Zero ports
    run_seq(32'd0, 32'h0000_4000, 32'h100, 32'h55, 1, 0, 0, 1, 0, 3, -1, 1'b0);
    chk(ar_cnt_m == 3, "t3_reads", ar_cnt_m, 3);
    chk(wlog.size() == 0, "t3_writes", wlog.size(), 0);
    chk(error == 1'b0, "t3_error", error, 0);

    // Too many ports, then a valid run clears the sticky error
    run_seq(32'd9, 32'h0, 32'h1000, 32'h77, 0, 0, 0, 0, 0, 3, -1, 1'b0);
    chk(error == 1'b1, "t4_error_set", error, 1);
    chk(wlog.size() == 0, "t4_writes", wlog.size(), 0);
    run_seq(32'd1, 32'h0, 32'h1000, 32'h78, 0, 0, 0, 0, 0, 3, -1, 1'b0);
    chk(error == 1'b0, "t4_error_cleared", error, 0);

    // SLVERR on the first of four writes
    run_seq(32'd4, 32'h0002_0000, 32'h400, 32'hCAFE, 0, 1, 2, 0, 1, 3, 0, 1'b0);
    chk(wlog.size() == 1, "t5_writes", wlog.size(), 1);
    chk(error == 1'b1, "t5_error", error, 1);

    // Reset while in WR_REQ
    cfg_count = 2; cfg_offset = 32'h0001_0000; cfg_stride = 32'h0001_0000;
    cfg_aw_wait = 10; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_r_dly = 0; cfg_b_dly = 0;
    cfg_rd_err = 3; cfg_wr_err = -1; s_wr_num = 0;
    model(32'd2, 32'h0001_0000, 32'h0001_0000, 32'h9, 3, -1);
    @(posedge clk); #1; start = 1'b1; wr_data = 32'h9;
    @(posedge clk); #1; start = 1'b0;
    c = 0;
    while (!axil.awvalid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(axil.awvalid == 1'b1, "t6_reach_wr_req", axil.awvalid, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) m_regs[i] = 32'd0;
    @(negedge clk);
    chk({axil.awvalid, axil.wvalid} == 2'b00, "t6_valids_low", {axil.awvalid, axil.wvalid}, 0);
    chk(busy == 1'b0, "t6_busy_low", busy, 0);
    chk(port_count == 32'd0, "t6_regs_cleared", port_count, 0);
    run_seq(32'd2, 32'h0001_0000, 32'h0001_0000, 32'h9, 0, 0, 0, 0, 0, 3, -1, 1'b0);
    chk(ar_cnt_m == 3, "t6_rerun_reads", ar_cnt_m, 3);
    chk(wlog.size() == 2, "t6_rerun_writes", wlog.size(), 2);

    // Randomized sequences
    for (int t = 0; t < 24; t++) begin
      r_cnt = 32'($urandom_range(0, 10));
      run_seq(r_cnt, $urandom(), $urandom(), $urandom(),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : 3,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
